// File: rtl/gan_fixed_pkg.sv
// Shared Q8.8 constants and sequencer state encoding for the discriminator datapath.
package gan_fixed_pkg;

  localparam int Q88_WIDTH     = 16;
  localparam int L3_NUM_INPUTS = 32;

  typedef enum logic [1:0] {
    SEQ_FILL,
    SEQ_FIRE,
    SEQ_WAIT,
    SEQ_HOLD
  } seq_state_e;

endpackage

// File: rtl/layer3_input_sequencer_if.sv
// Stream-in, layer-side and result-out signals of the layer-3 input sequencer.
interface layer3_input_sequencer_if
  import gan_fixed_pkg::*;
#(
  parameter int NUM_INPUTS = L3_NUM_INPUTS,
  parameter int DATA_WIDTH = Q88_WIDTH
);

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] flat_input_flat;
  logic                             layer_start;
  logic                             layer_done;
  logic [DATA_WIDTH-1:0]            layer_score;
  logic                             layer_decision;
  logic                             res_valid;
  logic                             res_ready;
  logic [DATA_WIDTH-1:0]            res_score;
  logic                             res_decision;
  logic                             res_timeout;
  logic                             busy;

  // master is the sequencer itself; slave is the surrounding datapath
  modport master (
    input  in_valid, in_data, layer_done, layer_score, layer_decision, res_ready,
    output in_ready, flat_input_flat, layer_start, res_valid, res_score,
           res_decision, res_timeout, busy
  );

  modport slave (
    output in_valid, in_data, layer_done, layer_score, layer_decision, res_ready,
    input  in_ready, flat_input_flat, layer_start, res_valid, res_score,
           res_decision, res_timeout, busy
  );

endinterface

// File: rtl/layer3_vector_packer.sv
// Slot register array that collects serial elements and presents them as one flat bus.
module layer3_vector_packer
  import gan_fixed_pkg::*;
#(
  parameter int NUM_INPUTS = L3_NUM_INPUTS,
  parameter int DATA_WIDTH = Q88_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             clear,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             last_write,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] flat
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);

  logic [IW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] slots [NUM_INPUTS];

  assign last_write = wr_en && (wr_idx == LAST_IDX);

  // The index parks on the last slot after the final write; only clear rewinds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        slots[wr_idx] <= wr_data;
      end
      if (clear) begin
        wr_idx <= '0;
      end else if (wr_en && (wr_idx != LAST_IDX)) begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      flat[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
    end
  end

endmodule

// File: rtl/layer3_input_sequencer.sv
// Initiator for the final discriminator layer: packs a vector, fires the layer, returns its result.
module layer3_input_sequencer
  import gan_fixed_pkg::*;
#(
  parameter int NUM_INPUTS     = L3_NUM_INPUTS,
  parameter int DATA_WIDTH     = Q88_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      rst,
  layer3_input_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e                       state;
  logic [TW-1:0]                    timer;
  logic                             wr_en;
  logic                             clear;
  logic                             fill_last;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] flat;
  logic                             in_ready_q;
  logic                             layer_start_q;
  logic                             res_valid_q;
  logic [DATA_WIDTH-1:0]            res_score_q;
  logic                             res_decision_q;
  logic                             res_timeout_q;
  logic                             busy_q;

  assign wr_en = bus.in_valid && in_ready_q;
  assign clear = (state == SEQ_HOLD) && res_valid_q && bus.res_ready;

  layer3_vector_packer #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .clear      (clear),
    .wr_data    (bus.in_data),
    .last_write (fill_last),
    .flat       (flat)
  );

  // Timer value 0 marks the guard cycle, so a done level left over from a previous run is never taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SEQ_FILL;
      timer          <= '0;
      in_ready_q     <= 1'b1;
      layer_start_q  <= 1'b0;
      res_valid_q    <= 1'b0;
      res_score_q    <= '0;
      res_decision_q <= 1'b0;
      res_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      layer_start_q <= 1'b0;
      case (state)
        SEQ_FILL: begin
          if (fill_last) begin
            state         <= SEQ_FIRE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            layer_start_q <= 1'b1;
          end
        end
        SEQ_FIRE: begin
          state <= SEQ_WAIT;
          timer <= '0;
        end
        SEQ_WAIT: begin
          timer <= timer + 1'b1;
          if ((timer != '0) && bus.layer_done) begin
            state          <= SEQ_HOLD;
            res_valid_q    <= 1'b1;
            res_score_q    <= bus.layer_score;
            res_decision_q <= bus.layer_decision;
            res_timeout_q  <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state          <= SEQ_HOLD;
            res_valid_q    <= 1'b1;
            res_score_q    <= '0;
            res_decision_q <= 1'b0;
            res_timeout_q  <= 1'b1;
          end
        end
        SEQ_HOLD: begin
          if (bus.res_ready) begin
            state       <= SEQ_FILL;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state <= SEQ_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.flat_input_flat = flat;
  assign bus.layer_start     = layer_start_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_score       = res_score_q;
  assign bus.res_decision    = res_decision_q;
  assign bus.res_timeout     = res_timeout_q;
  assign bus.busy            = busy_q;

endmodule
